fir_feeder: RTL

FIR_FEEDER -- requirements
Module: fir_feeder

---
 rtl/fir_feeder_pkg.sv | 20 ++
 rtl/fir_feeder_if.sv | 37 +++
 rtl/fir_feeder_sample_fifo.sv | 62 ++++++
 rtl/fir_feeder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fir_feeder_pkg.sv
// Shared types and defaults for the FIR feeder: state encoding, word type, sizing defaults.
// No logic here.
package fir_feeder_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int NUM_COEFF_DEF  = 4;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LC_ISSUE,
    LC_WAIT_HI,
    LC_WAIT_LO,
    DR_ISSUE,
    DR_WAIT_HI,
    DR_WAIT_LO
  } state_t;

endpackage

// File: rtl/fir_feeder_if.sv
// Bundle of producer, coefficient-host and filter-side signals of the FIR feeder.
// slave = feeder view, master = environment view.
interface fir_feeder_if;
  import fir_feeder_pkg::*;

  word_t       sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        coeff_wr;
  logic [1:0]  coeff_addr;
  word_t       coeff_in;
  logic        coeff_commit;
  logic        modwait;
  logic        err;
  word_t       sample_data;
  word_t       fir_coefficient;
  logic        data_ready;
  logic        load_coeff;
  logic [4:0]  fifo_count;
  logic        coeff_loaded;
  logic [7:0]  err_count;

  modport slave (
    input  sample_in, sample_valid, coeff_wr, coeff_addr, coeff_in,
           coeff_commit, modwait, err,
    output sample_ready, sample_data, fir_coefficient, data_ready,
           load_coeff, fifo_count, coeff_loaded, err_count
  );

  modport master (
    output sample_in, sample_valid, coeff_wr, coeff_addr, coeff_in,
           coeff_commit, modwait, err,
    input  sample_ready, sample_data, fir_coefficient, data_ready,
           load_coeff, fifo_count, coeff_loaded, err_count
  );

endinterface

// File: rtl/fir_feeder_sample_fifo.sv
// First-word-fall-through sample FIFO; head valid the cycle after a push, pop takes effect at the edge.
// Pushes while full and pops while empty are ignored.
module sample_fifo
  import fir_feeder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  word_t      i_dat,
  input  logic       i_pop,
  output word_t      o_head,
  output logic       o_empty,
  output logic       o_full,
  output logic [4:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  word_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [4:0]     r_count;
  logic           w_push;
  logic           w_pop;

  assign o_empty = (r_count == 5'd0);
  assign o_full  = (r_count == 5'(DEPTH));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage carries no reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fir_feeder.sv
// Feeds queued samples and coefficient reloads to a FIR filter with a modwait handshake.
// Strobe one cycle after IDLE sees work with modwait low; producer stalls via sample_ready when FIFO full.
module fir_feeder
  import fir_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int NUM_COEFF  = NUM_COEFF_DEF
) (
  input  logic             clk,
  input  logic             rst,
  fir_feeder_if.slave      io_bus
);

  localparam int KW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;

  state_t         r_state;
  state_t         w_state_next;
  logic [KW-1:0]  r_k;
  logic [KW-1:0]  w_k_next;
  logic           w_lc_start;
  logic           w_lc_done;
  logic           r_pending;
  logic           r_coeff_loaded;
  logic           r_err_d;
  logic [7:0]     r_err_count;
  word_t          r_bank [NUM_COEFF];
  word_t          r_sample_data;
  word_t          r_fir_coeff;
  word_t          w_head;
  logic           w_empty;
  logic           w_full;
  logic           w_pop;
  logic [4:0]     w_count;

  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (io_bus.sample_valid),
    .i_dat   (io_bus.sample_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign w_pop = (r_state == DR_ISSUE);

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_lc_start   = 1'b0;
    w_lc_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!io_bus.modwait) begin
          if (r_pending) begin
            w_state_next = LC_ISSUE;
            w_k_next     = '0;
            w_lc_start   = 1'b1;
          end else if (!w_empty) begin
            w_state_next = DR_ISSUE;
          end
        end
      end
      LC_ISSUE:   w_state_next = LC_WAIT_HI;
      LC_WAIT_HI: if (io_bus.modwait) w_state_next = LC_WAIT_LO;
      LC_WAIT_LO: begin
        if (!io_bus.modwait) begin
          if (r_k == KW'(NUM_COEFF - 1)) begin
            w_state_next = IDLE;
            w_k_next     = '0;
            w_lc_done    = 1'b1;
          end else begin
            w_state_next = LC_ISSUE;
            w_k_next     = r_k + 1'b1;
          end
        end
      end
      DR_ISSUE:   w_state_next = DR_WAIT_HI;
      DR_WAIT_HI: if (io_bus.modwait) w_state_next = DR_WAIT_LO;
      DR_WAIT_LO: if (!io_bus.modwait) w_state_next = IDLE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
    end
  end

  // Output words are captured on the edge entering an issue state, so they are
  // already valid during the strobe cycle and hold until the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending      <= 1'b0;
      r_coeff_loaded <= 1'b0;
      r_sample_data  <= '0;
      r_fir_coeff    <= '0;
      r_err_d        <= 1'b0;
      r_err_count    <= 8'd0;
      for (int i = 0; i < NUM_COEFF; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      if (io_bus.coeff_commit) begin
        r_pending <= 1'b1;
      end else if (w_lc_start) begin
        r_pending <= 1'b0;
      end
      if (w_lc_start) begin
        r_coeff_loaded <= 1'b0;
      end else if (w_lc_done) begin
        r_coeff_loaded <= 1'b1;
      end
      if (w_state_next == LC_ISSUE) begin
        r_fir_coeff <= r_bank[w_k_next];
      end
      if (w_state_next == DR_ISSUE) begin
        r_sample_data <= w_head;
      end
      for (int i = 0; i < NUM_COEFF; i++) begin
        if (io_bus.coeff_wr && (io_bus.coeff_addr == 2'(i))) begin
          r_bank[i] <= io_bus.coeff_in;
        end
      end
      r_err_d <= io_bus.err;
      if (io_bus.err && !r_err_d && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  // Strobes are masked by rst so an aborted handshake never fires in the reset cycle.
  assign io_bus.load_coeff      = (r_state == LC_ISSUE) && !rst;
  assign io_bus.data_ready      = (r_state == DR_ISSUE) && !rst;
  assign io_bus.sample_ready    = !w_full;
  assign io_bus.fifo_count      = w_count;
  assign io_bus.sample_data     = r_sample_data;
  assign io_bus.fir_coefficient = r_fir_coeff;
  assign io_bus.coeff_loaded    = r_coeff_loaded;
  assign io_bus.err_count       = r_err_count;

endmodule
